apb_slave_regfile: RTL and testbench



---
 rtl/apb_pkg.sv | 43 ++++
 rtl/apb_slave_regfile_if.sv | 23 ++
 rtl/apb_regbank.sv | 33 +++
 rtl/apb_slave_regfile.sv | 116 +++++++++++
 tb/tb_apb_slave_regfile.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and constants for the register-file completer.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 4;
    localparam logic [APB_DATA_W-1:0] DEFAULT_ID = 32'hA5B0_0001;

    typedef enum logic {IDLE, ACCESS} state_e;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_WINDOW = 3'd1,
        ERR_ALIGN  = 3'd2,
        ERR_RANGE  = 3'd3,
        ERR_RO     = 3'd4
    } err_cause_e;

    typedef struct packed {
        logic                  write;
        logic [IDX_W-1:0]      idx;
        logic [APB_DATA_W-1:0] wdata;
        err_cause_e            cause;
    } req_t;

    // Classify an access; the first failing rule wins so the cause is unambiguous.
    function automatic err_cause_e decode_err(
        input logic [APB_ADDR_W-1:0] addr,
        input logic                  write,
        input logic [25:0]           base_hi,
        input int unsigned           num_regs
    );
        logic [IDX_W-1:0] idx;
        idx = addr[5:2];
        if (addr[31:6] != base_hi)                  return ERR_WINDOW;
        if (addr[1:0] != 2'b00)                     return ERR_ALIGN;
        if (32'(idx) >= num_regs)                   return ERR_RANGE;
        if (write && (32'(idx) == num_regs - 1))    return ERR_RO;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and a completer (slave).
interface apb_slave_regfile_if;
    import apb_pkg::*;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_ADDR_W-1:0] PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regbank.sv
// Word register array with a synchronous write port and a read-only ID slot at the top index.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int unsigned           NUM_REGS = 16,
    parameter logic [APB_DATA_W-1:0] ID_VALUE = DEFAULT_ID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata_c
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else if (we && (32'(widx) < NUM_REGS - 1)) begin
            regs[widx] <= wdata;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (32'(ridx) == NUM_REGS - 1)  rdata_c = ID_VALUE;
        else if (32'(ridx) < NUM_REGS)  rdata_c = regs[ridx];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: setup-phase latch, programmable wait states, error response, and a register bank.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           WAIT_STATES = 1,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = DEFAULT_ID
) (
    input logic                HCLK,
    input logic                HRESET,
    apb_slave_regfile_if.slave bus
);

    state_e                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    req_t                  req, req_nx;
    logic                  ready_nx, slverr_nx;
    logic [APB_DATA_W-1:0] rdata_nx;
    logic                  we_c;
    logic [IDX_W-1:0]      ridx_c;
    logic [APB_DATA_W-1:0] bank_rdata_c;
    err_cause_e            cause_c;

    apb_regbank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk     (HCLK),
        .rst     (HRESET),
        .we      (we_c),
        .widx    (req.idx),
        .wdata   (req.wdata),
        .ridx    (ridx_c),
        .rdata_c (bank_rdata_c)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            req         <= '0;
            bus.PREADY  <= 1'b0;
            bus.PSLVERR <= 1'b0;
            bus.PRDATA  <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            req         <= req_nx;
            bus.PREADY  <= ready_nx;
            bus.PSLVERR <= slverr_nx;
            bus.PRDATA  <= rdata_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_nx    = req;
        ready_nx  = bus.PREADY;
        slverr_nx = bus.PSLVERR;
        rdata_nx  = bus.PRDATA;
        we_c      = 1'b0;
        ridx_c    = req.idx;
        cause_c   = decode_err(bus.PADDR, bus.PWRITE, BASE_ADDR[31:6], NUM_REGS);

        unique case (state)
            IDLE: begin
                // With zero wait states the response is launched straight from the setup phase.
                ridx_c    = bus.PADDR[5:2];
                ready_nx  = 1'b0;
                slverr_nx = 1'b0;
                rdata_nx  = '0;
                if (bus.PSEL && !bus.PENABLE) begin
                    req_nx.write = bus.PWRITE;
                    req_nx.idx   = bus.PADDR[5:2];
                    req_nx.wdata = bus.PWDATA;
                    req_nx.cause = cause_c;
                    state_nx     = ACCESS;
                    if (WAIT_STATES == 0) begin
                        ready_nx  = 1'b1;
                        slverr_nx = (cause_c != ERR_NONE);
                        rdata_nx  = (!bus.PWRITE && cause_c == ERR_NONE) ? bank_rdata_c : '0;
                    end else begin
                        cnt_nx = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    ready_nx  = 1'b0;
                    slverr_nx = 1'b0;
                    rdata_nx  = '0;
                end else if (bus.PREADY) begin
                    if (bus.PENABLE) begin
                        we_c      = req.write && (req.cause == ERR_NONE);
                        state_nx  = IDLE;
                        ready_nx  = 1'b0;
                        slverr_nx = 1'b0;
                        rdata_nx  = '0;
                    end
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    ready_nx  = 1'b1;
                    slverr_nx = (req.cause != ERR_NONE);
                    rdata_nx  = (!req.write && req.cause == ERR_NONE) ? bank_rdata_c : '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: two completers (0 and 3 wait states) on a shared stimulus bus.
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int unsigned NREGS  = 16;
    localparam logic [31:0] ID_VAL = 32'hA5B0_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready_m, pslverr_m;
    logic [31:0] prdata_m;

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus3 ();

    assign bus0.PSEL    = psel & ~sel;
    assign bus3.PSEL    = psel & sel;
    assign bus0.PENABLE = penable;
    assign bus3.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;
    assign bus3.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;
    assign bus3.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;
    assign bus3.PWDATA  = pwdata;

    assign pready_m  = sel ? bus3.PREADY  : bus0.PREADY;
    assign pslverr_m = sel ? bus3.PSLVERR : bus0.PSLVERR;
    assign prdata_m  = sel ? bus3.PRDATA  : bus0.PRDATA;

    apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(NREGS), .WAIT_STATES(0), .ID_VALUE(ID_VAL))
        dut0 (.HCLK(clk), .HRESET(rst), .bus(bus0));
    apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(NREGS), .WAIT_STATES(3), .ID_VALUE(ID_VAL))
        dut3 (.HCLK(clk), .HRESET(rst), .bus(bus3));

    int errors = 0;
    int checks = 0;

    // Reference contents of each completer's writable words.
    logic [31:0] mdl [2][16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic mdl_err(input logic w, input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE || a >= BASE + 32'(4 * NREGS)) return 1'b1;
        off = a - BASE;
        if (off % 4 != 0) return 1'b1;
        if (w && (off / 4 == NREGS - 1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input logic s, input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) / 4;
        if (idx == NREGS - 1) return ID_VAL;
        return mdl[s][idx[3:0]];
    endfunction

    task automatic mdl_apply(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] idx;
        idx = (a - BASE) / 4;
        if (w && !mdl_err(w, a)) mdl[s][idx[3:0]] = d;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) mdl[i][j] = '0;
    endtask

    // Entered and left at #1 after a rising edge; address/data are scrambled during access.
    task automatic xfer(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int waits);
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        waits   = 0;
        while (!pready_m && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!pready_m) chk("timeout", 32'(pready_m), 32'd1);
        rd = prdata_m;
        er = pslverr_m;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        mdl_apply(s, w, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic        s;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_waits;
    } vec_t;

    vec_t vt [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w8;
        logic [31:0] a;
        logic        wr;
        logic [31:0] d;
        logic [1:0]  kind;

        rst = 1'b1; sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        mdl_clear();
        idle(3);
        sel = 1'b0; #0;
        chk("reset_pready0", 32'(pready_m), 32'd0);
        chk("reset_prdata0", prdata_m, 32'd0);
        sel = 1'b1; #1;
        chk("reset_pready3", 32'(pready_m), 32'd0);
        chk("reset_pslverr3", 32'(pslverr_m), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        vt.push_back('{1'b0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0, 0});
        vt.push_back('{1'b0, 1'b0, 32'h8000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 0});
        vt.push_back('{1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 32'h0,         1'b0, 3});
        vt.push_back('{1'b1, 1'b0, 32'h8000_0004, 32'h0,         32'h1234_5678, 1'b0, 3});
        vt.push_back('{1'b1, 1'b1, 32'h9000_0000, 32'h1111_1111, 32'h0,         1'b1, 3});
        vt.push_back('{1'b1, 1'b1, 32'h8000_0002, 32'h2222_2222, 32'h0,         1'b1, 3});
        vt.push_back('{1'b1, 1'b1, 32'h8000_003C, 32'h3333_3333, 32'h0,         1'b1, 3});
        vt.push_back('{1'b1, 1'b0, 32'h8000_003C, 32'h0,         32'hA5B0_0001, 1'b0, 3});
        vt.push_back('{1'b1, 1'b0, 32'h8000_0004, 32'h0,         32'h1234_5678, 1'b0, 3});
        vt.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 3});
        vt.push_back('{1'b1, 1'b0, 32'h9000_0000, 32'h0,         32'h0,         1'b1, 3});
        vt.push_back('{1'b0, 1'b0, 32'h8000_003C, 32'h0,         32'hA5B0_0001, 1'b0, 0});

        foreach (vt[i]) begin
            xfer(vt[i].s, vt[i].w, vt[i].a, vt[i].d, rd, er, w8);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_er));
            chk($sformatf("vec%0d_waits", i), 32'(w8), 32'(vt[i].exp_waits));
            chk($sformatf("vec%0d_cleared", i), 32'(pready_m), 32'd0);
            idle(1);
        end

        // Back-to-back write then read on both completers, no idle cycle between.
        for (int s = 0; s < 2; s++) begin
            xfer(1'(s), 1'b1, 32'h8000_0000, 32'h1, rd, er, w8);
            xfer(1'(s), 1'b0, 32'h8000_0000, 32'h0, rd, er, w8);
            chk($sformatf("b2b%0d_rdata", s), rd, 32'h1);
            chk($sformatf("b2b%0d_waits", s), 32'(w8), (s == 0) ? 32'd0 : 32'd3);
            idle(1);
        end

        // PSEL with PENABLE from idle is not a setup phase and must be ignored.
        sel = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8000_0008;
        @(posedge clk); #1;
        chk("viol_ready_a", 32'(pready_m), 32'd0);
        @(posedge clk); #1;
        chk("viol_ready_b", 32'(pready_m), 32'd0);
        psel = 1'b0; penable = 1'b0;
        idle(1);

        // Abort a waited write by dropping PSEL.
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0010; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("abort_wait_ready", 32'(pready_m), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 32'(pready_m), 32'd0);
        chk("abort_rdata", prdata_m, 32'd0);
        idle(1);
        xfer(1'b1, 1'b0, 32'h8000_0010, 32'h0, rd, er, w8);
        chk("abort_reg", rd, 32'h0);
        chk("abort_waits", 32'(w8), 32'd3);
        idle(1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            kind = 2'($urandom_range(0, 3));
            case (kind)
                2'd0:    a = $urandom;
                2'd1:    a = BASE + 32'($urandom_range(0, 63));
                default: a = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            wr = 1'($urandom);
            d  = $urandom;
            sel = 1'($urandom);
            begin
                logic        s_cur;
                logic        exp_er;
                logic [31:0] exp_rd;
                s_cur  = sel;
                exp_er = mdl_err(wr, a);
                exp_rd = (!wr && !exp_er) ? mdl_read(s_cur, a) : 32'h0;
                xfer(s_cur, wr, a, d, rd, er, w8);
                chk($sformatf("rnd%0d_rdata a=%h", n, a), rd, exp_rd);
                chk($sformatf("rnd%0d_err a=%h", n, a), 32'(er), 32'(exp_er));
                chk($sformatf("rnd%0d_waits", n), 32'(w8), s_cur ? 32'd3 : 32'd0);
            end
            idle(int'($urandom_range(0, 2)));
        end

        // Reset while a read response is being presented.
        xfer(1'b1, 1'b1, 32'h8000_0004, 32'h0BAD_F00D, rd, er, w8);
        idle(1);
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8000_0004;
        @(posedge clk); #1;
        penable = 1'b1;
        w8 = 0;
        while (!pready_m && w8 < 40) begin @(posedge clk); #1; w8++; end
        chk("rstmid_pre_ready", 32'(pready_m), 32'd1);
        chk("rstmid_pre_rdata", prdata_m, 32'h0BAD_F00D);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ready", 32'(pready_m), 32'd0);
        chk("rstmid_rdata", prdata_m, 32'd0);
        psel = 1'b0; penable = 1'b0;
        mdl_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        xfer(1'b1, 1'b0, 32'h8000_0004, 32'h0, rd, er, w8);
        chk("rstmid_reg", rd, 32'h0);
        chk("rstmid_waits", 32'(w8), 32'd3);
        xfer(1'b1, 1'b0, 32'h8000_003C, 32'h0, rd, er, w8);
        chk("rstmid_id", rd, 32'hA5B0_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
